// File: rtl/if_stage.sv
// Instruction fetch stage: PC, IF/ID register and a one-entry skid buffer for decode stalls.
// Optional misaligned-redirect trap enabled by defining IF_MISALIGN_TRAP_EN.
module if_stage #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        stall_id,
  input  logic        flush,
  input  logic [31:0] branch_target,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_rdata,
  input  logic        imem_ack,
  output logic [31:0] instr_out,
  output logic [31:0] pc_plus4_out,
  output logic        valid_out,
  output logic        fault_out
);

  typedef enum logic [1:0] {
    FETCH = 2'd0,
    HOLD  = 2'd1
`ifdef IF_MISALIGN_TRAP_EN
    , HALT = 2'd2
`endif
  } state_t;

  state_t      state, state_nxt;
  logic [31:0] pc_p0;
  logic [31:0] skid_instr_p0;
  logic [31:0] skid_pc4_p0;
  logic        take_ack;
  logic        halted;
  logic        misalign;
  state_t      flush_state;

  function automatic logic [31:0] pc_inc(input logic [31:0] pc);
    return pc + 32'd4;
  endfunction

  function automatic logic [31:0] redirect_addr(input logic [31:0] target);
`ifdef IF_MISALIGN_TRAP_EN
    return target;
`else
    return {target[31:2], 2'b00};
`endif
  endfunction

  assign imem_addr = pc_p0;
  assign take_ack  = imem_req & imem_ack;

`ifdef IF_MISALIGN_TRAP_EN
  assign halted      = (state == HALT);
  assign misalign    = |branch_target[1:0];
  assign flush_state = misalign ? HALT : FETCH;
`else
  assign halted      = 1'b0;
  assign misalign    = 1'b0;
  assign flush_state = FETCH;
  assign fault_out   = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (reset) state <= FETCH;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      FETCH: begin
        if (flush)                    state_nxt = flush_state;
        else if (take_ack && stall_id) state_nxt = HOLD;
      end
      HOLD: begin
        if (flush)          state_nxt = flush_state;
        else if (!stall_id) state_nxt = FETCH;
      end
`ifdef IF_MISALIGN_TRAP_EN
      HALT:    state_nxt = HALT;
`endif
      default: state_nxt = FETCH;
    endcase
  end

  always_comb begin
    imem_req = (state == FETCH) && !reset;
  end

  // IF -> ID boundary: IF/ID register and skid buffer
  always_ff @(posedge clk) begin
    if (reset) begin
      pc_p0         <= RESET_PC;
      instr_out     <= '0;
      pc_plus4_out  <= '0;
      valid_out     <= 1'b0;
      skid_instr_p0 <= '0;
      skid_pc4_p0   <= '0;
    end else if (halted) begin
      valid_out <= 1'b0;
    end else if (flush) begin
      pc_p0     <= redirect_addr(branch_target);
      valid_out <= 1'b0;
    end else if (state == FETCH) begin
      if (take_ack) begin
        pc_p0 <= pc_inc(pc_p0);
        if (stall_id) begin
          skid_instr_p0 <= imem_rdata;
          skid_pc4_p0   <= pc_inc(pc_p0);
        end else begin
          instr_out    <= imem_rdata;
          pc_plus4_out <= pc_inc(pc_p0);
          valid_out    <= 1'b1;
        end
      end else if (!stall_id) begin
        valid_out <= 1'b0;
      end
    end else if (state == HOLD && !stall_id) begin
      instr_out    <= skid_instr_p0;
      pc_plus4_out <= skid_pc4_p0;
      valid_out    <= 1'b1;
    end
  end

`ifdef IF_MISALIGN_TRAP_EN
  always_ff @(posedge clk) begin
    if (reset)                   fault_out <= 1'b0;
    else if (flush && !halted)   fault_out <= fault_out | misalign;
  end
`endif

endmodule

// File: tb/tb_if_stage.sv
// Self-checking bench for if_stage: directed scenarios plus random traffic against a queue-based model.
module tb_if_stage;

  localparam logic [31:0] RST_PC = 32'h0000_0040;
`ifdef IF_MISALIGN_TRAP_EN
  localparam bit TRAP = 1'b1;
`else
  localparam bit TRAP = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset, stall_id, flush, imem_ack;
  logic [31:0] branch_target, imem_rdata;
  logic        imem_req, valid_out, fault_out;
  logic [31:0] imem_addr, instr_out, pc_plus4_out;

  always #5 clk = ~clk;

  if_stage #(.RESET_PC(RST_PC)) dut (
    .clk          (clk),
    .reset        (reset),
    .stall_id     (stall_id),
    .flush        (flush),
    .branch_target(branch_target),
    .imem_req     (imem_req),
    .imem_addr    (imem_addr),
    .imem_rdata   (imem_rdata),
    .imem_ack     (imem_ack),
    .instr_out    (instr_out),
    .pc_plus4_out (pc_plus4_out),
    .valid_out    (valid_out),
    .fault_out    (fault_out)
  );

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic [31:0] instr;
    logic [31:0] pc4;
  } word_t;

  // model: words acked while decode stalled wait in a queue until decode accepts them
  word_t       pend[$];
  logic [31:0] m_pc, m_instr, m_pc4;
  logic        m_valid, m_fault, m_halt;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_pc = RST_PC; m_instr = '0; m_pc4 = '0;
    m_valid = 1'b0; m_fault = 1'b0; m_halt = 1'b0;
    pend.delete();
  endtask

  task automatic model_update();
    word_t w;
    if (reset) begin
      model_reset();
    end else if (m_halt) begin
      m_valid = 1'b0;
    end else if (flush) begin
      if (TRAP && branch_target[1:0] != 2'b00) begin
        m_fault = 1'b1;
        m_halt  = 1'b1;
        m_pc    = branch_target;
      end else begin
        m_pc = branch_target & 32'hFFFF_FFFC;
      end
      m_valid = 1'b0;
      pend.delete();
    end else if (pend.size() > 0) begin
      if (!stall_id) begin
        w = pend.pop_front();
        m_instr = w.instr; m_pc4 = w.pc4; m_valid = 1'b1;
      end
    end else if (imem_ack) begin
      w.instr = imem_rdata;
      w.pc4   = m_pc + 32'd4;
      m_pc    = m_pc + 32'd4;
      if (stall_id) pend.push_back(w);
      else begin
        m_instr = w.instr; m_pc4 = w.pc4; m_valid = 1'b1;
      end
    end else if (!stall_id) begin
      m_valid = 1'b0;
    end
  endtask

  task automatic check_all();
    logic exp_req;
    exp_req = !reset && !m_halt && (pend.size() == 0);
    chk("imem_req",     {31'd0, imem_req},  {31'd0, exp_req});
    chk("imem_addr",    imem_addr,          m_pc);
    chk("valid_out",    {31'd0, valid_out}, {31'd0, m_valid});
    chk("instr_out",    instr_out,          m_instr);
    chk("pc_plus4_out", pc_plus4_out,       m_pc4);
    chk("fault_out",    {31'd0, fault_out}, {31'd0, m_fault});
  endtask

  // drive on negedge, compare before the edge, advance the model, leave caller at posedge+1
  task automatic step(input logic r, input logic st, input logic fl,
                      input logic [31:0] tgt, input logic ak, input logic [31:0] rd);
    @(negedge clk);
    reset = r; stall_id = st; flush = fl; branch_target = tgt; imem_ack = ak; imem_rdata = rd;
    #1;
    check_all();
    @(posedge clk);
    #1;
    model_update();
  endtask

  initial begin
    logic        r, st, fl, ak;
    logic [31:0] tgt;

    reset = 1'b1; stall_id = 1'b0; flush = 1'b0; imem_ack = 1'b0;
    branch_target = '0; imem_rdata = '0;
    repeat (2) @(posedge clk);
    #1;
    model_reset();

    // reset dominates flush/stall/ack
    step(1, 1, 1, 32'h0000_0200, 1, 32'h1111_1111);
    chk("rst_req_low",  {31'd0, imem_req},  32'd0);
    chk("rst_addr",     imem_addr,          32'h0000_0040);
    chk("rst_valid",    {31'd0, valid_out}, 32'd0);
    chk("rst_instr",    instr_out,          32'd0);
    chk("rst_pc4",      pc_plus4_out,       32'd0);
    chk("rst_fault",    {31'd0, fault_out}, 32'd0);

    // streaming fetch from RESET_PC
    step(0, 0, 0, 0, 1, 32'hA000_0001);
    chk("seq_addr1", imem_addr,    32'h0000_0044);
    chk("seq_pc4_1", pc_plus4_out, 32'h0000_0044);
    chk("seq_ins1",  instr_out,    32'hA000_0001);
    step(0, 0, 0, 0, 1, 32'hA000_0002);
    chk("seq_addr2", imem_addr,    32'h0000_0048);
    chk("seq_pc4_2", pc_plus4_out, 32'h0000_0048);
    chk("seq_val2",  {31'd0, valid_out}, 32'd1);

    // ack while decode stalled, held for three cycles
    step(0, 1, 0, 0, 1, 32'h8C22_0004);
    chk("hold_instr_kept", instr_out, 32'hA000_0002);
    for (int i = 0; i < 3; i++) begin
      step(0, 1, 0, 0, 1, $urandom);
      chk("hold_req_low", {31'd0, imem_req}, 32'd0);
      chk("hold_addr",    imem_addr,         32'h0000_004C);
    end
    step(0, 0, 0, 0, 1, 32'h5555_5555);
    chk("hold_release_instr", instr_out,          32'h8C22_0004);
    chk("hold_release_valid", {31'd0, valid_out}, 32'd1);
    chk("hold_release_addr",  imem_addr,          32'h0000_004C);
    step(0, 0, 0, 0, 1, 32'hB000_0003);
    chk("after_hold_pc4", pc_plus4_out, 32'h0000_0050);

    // flush beats ack and stall in the same cycle
    step(0, 1, 1, 32'h0000_0100, 1, 32'hDEAD_BEEF);
    chk("flush_valid", {31'd0, valid_out}, 32'd0);
    chk("flush_addr",  imem_addr,          32'h0000_0100);
    step(0, 0, 0, 0, 0, 32'h0);
    chk("flush_killed", {31'd0, instr_out == 32'hDEAD_BEEF}, 32'd0);

    // PC wraps modulo 2^32
    step(0, 0, 1, 32'hFFFF_FFFC, 0, 32'h0);
    step(0, 0, 0, 0, 1, 32'hCAFE_F00D);
    chk("wrap_pc4",  pc_plus4_out, 32'h0000_0000);
    chk("wrap_addr", imem_addr,    32'h0000_0000);

    // reset while a word sits in the skid buffer
    step(0, 1, 0, 0, 1, 32'h7777_7777);
    step(1, 1, 0, 0, 0, 32'h0);
    chk("rst_hold_valid", {31'd0, valid_out}, 32'd0);
    chk("rst_hold_addr",  imem_addr,          RST_PC);
    step(0, 0, 0, 0, 0, 32'h0);
    chk("rst_hold_dropped", {31'd0, valid_out}, 32'd0);

    // random traffic
    for (int i = 0; i < 400; i++) begin
      r   = ($urandom_range(0, 49) == 0);
      fl  = ($urandom_range(0, 9) == 0);
      st  = ($urandom_range(0, 2) == 0);
      ak  = ($urandom_range(0, 3) != 0);
      tgt = $urandom;
      if (TRAP) tgt[1:0] = 2'b00;
      step(r, st, fl, tgt, ak, $urandom);
    end

    // misaligned redirect
    step(1, 0, 0, 0, 0, 32'h0);
    step(0, 0, 1, 32'h0000_0102, 1, 32'h9999_9999);
`ifdef IF_MISALIGN_TRAP_EN
    chk("trap_fault", {31'd0, fault_out}, 32'd1);
    for (int i = 0; i < 3; i++) begin
      step(0, 0, 1, 32'h0000_0200, 1, $urandom);
      chk("trap_req_low", {31'd0, imem_req},  32'd0);
      chk("trap_valid",   {31'd0, valid_out}, 32'd0);
    end
    step(1, 0, 0, 0, 0, 32'h0);
    chk("trap_cleared", {31'd0, fault_out}, 32'd0);
`else
    chk("align_addr",  imem_addr,          32'h0000_0100);
    chk("align_fault", {31'd0, fault_out}, 32'd0);
`endif
    step(0, 0, 0, 0, 1, 32'h1234_5678);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
